ifetch_responder: RTL and testbench

IFETCH_RESPONDER -- requirements
Module: ifetch_responder

---
 rtl/ifetch_responder.sv | 186 ++++++++++++++++++
 tb/tb_ifetch_responder.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ifetch_responder.sv
// ifetch_responder
//
// Instruction-fetch responder. It serves 32-bit instruction fetches from a
// small word-addressed store that a loader port fills. A fetch is sampled in
// IDLE, optionally delayed by wait states in WAIT, and answered in ACK with a
// registered one-cycle acknowledge. A misaligned address, an address outside
// the window, or an unsupported size returns 0 (an illegal instruction) with
// err_o set.
//
// Parameters
//   AW    word-address width of the store (2**AW 32-bit words)
//   BASE  byte address of store word 0; the window covers
//         BASE .. BASE + 4*2**AW - 1
//
// Ports
//   clk_i     sole clock, rising edge
//   reset_i   synchronous, active-low reset
//   isiz_i    fetch size: 00 idle, 10 word, 01/11 unsupported (fault)
//   iadr_i    fetch byte address
//   ws_i      wait-state count 0-15 (only with IFETCH_WAITSTATES_EN)
//   ld_we_i   loader write enable (honoured in every state, even in reset)
//   ld_adr_i  loader word address
//   ld_dat_i  loader write data
//   iack_o    fetch acknowledge, one-cycle pulse
//   idat_o    fetched instruction, 0 whenever iack_o is low
//   err_o     fault flag, pulses together with iack_o
//
// Build option
//   IFETCH_WAITSTATES_EN  when defined, the ws_i port exists and its value is
//                         sampled with each request. When undefined, every
//                         fetch has zero wait states and WAIT is never entered.

module ifetch_responder #(
  parameter int          AW   = 6,
  parameter logic [63:0] BASE = 64'hFFFF_FFFF_FFFF_FF00
) (
  input  logic          clk_i,
  input  logic          reset_i,
  input  logic [1:0]    isiz_i,
  input  logic [63:0]   iadr_i,
`ifdef IFETCH_WAITSTATES_EN
  input  logic [3:0]    ws_i,
`endif
  input  logic          ld_we_i,
  input  logic [AW-1:0] ld_adr_i,
  input  logic [31:0]   ld_dat_i,
  output logic          iack_o,
  output logic [31:0]   idat_o,
  output logic          err_o
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    ACK  = 2'd2
  } state_t;

  localparam logic [1:0] SIZ_IDLE = 2'b00;
  localparam logic [1:0] SIZ_WORD = 2'b10;

  // Wait-state count for a new request.
  logic [3:0] ws_val;
`ifdef IFETCH_WAITSTATES_EN
  assign ws_val = ws_i;
`else
  assign ws_val = 4'd0;
`endif

  // Instruction store.
  logic [31:0] mem [2**AW];

  // NOTE: storage arrays get no reset branch; clearing them needs a reset
  // port on every word and rules out a RAM macro. Contents survive reset.
  always_ff @(posedge clk_i) begin
    if (ld_we_i) begin
      mem[ld_adr_i] <= ld_dat_i;
    end
  end

  // Control and request state.
  state_t      state;
  state_t      state_d;
  logic [3:0]  cnt;
  logic [3:0]  cnt_d;
  logic [63:0] lat_adr;
  logic [1:0]  lat_siz;

  // Registered output values.
  logic        ack_d;
  logic [31:0] dat_d;
  logic        err_d;

  logic        req;
  assign req = (isiz_i != SIZ_IDLE);

  // Process 1: state register, request latch and output registers.
  // NOTE: clocked state uses non-blocking assignments so every register
  // samples pre-edge values. This also gives read-before-write on the store.
  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      state   <= IDLE;
      cnt     <= 4'd0;
      lat_adr <= 64'd0;
      lat_siz <= 2'b00;
      iack_o  <= 1'b0;
      idat_o  <= 32'd0;
      err_o   <= 1'b0;
    end else begin
      state  <= state_d;
      cnt    <= cnt_d;
      iack_o <= ack_d;
      idat_o <= dat_d;
      err_o  <= err_d;
      if (state == IDLE && req) begin
        lat_adr <= iadr_i;
        lat_siz <= isiz_i;
      end
    end
  end

  // Process 2: next state and wait-state counter.
  // NOTE: every always_comb target is given a default first so no path
  // leaves it unassigned, which would infer a latch.
  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    case (state)
      IDLE: begin
        if (req) begin
          cnt_d   = ws_val;
          state_d = (ws_val != 4'd0) ? WAIT : ACK;
        end
      end
      WAIT: begin
        if (!req) begin
          // The CPU withdrew the request, so drop it silently.
          state_d = IDLE;
          cnt_d   = 4'd0;
        end else begin
          cnt_d = cnt - 4'd1;
          if (cnt == 4'd1) begin
            state_d = ACK;
          end
        end
      end
      ACK:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Process 3: values loaded into the output registers.
  // When leaving IDLE straight to ACK the latch has not captured the request
  // yet, so the live inputs are used. From WAIT the latched copy is used,
  // which makes mid-wait address and size changes invisible.
  logic [63:0]   eff_adr;
  logic [1:0]    eff_siz;
  logic [63:0]   offset;
  logic          in_window;
  logic          fault;
  logic [AW-1:0] word_idx;
  logic          unused_offset_bits;

  assign eff_adr   = (state == IDLE) ? iadr_i : lat_adr;
  assign eff_siz   = (state == IDLE) ? isiz_i : lat_siz;
  // The window test uses a wrapping 64-bit subtraction. An address below BASE
  // wraps to a huge offset and lands outside the window.
  assign offset    = eff_adr - BASE;
  assign in_window = (offset[63:AW+2] == '0);
  assign fault     = (eff_siz != SIZ_WORD) || (eff_adr[1:0] != 2'b00) || !in_window;
  assign word_idx  = offset[AW+1:2];
  assign unused_offset_bits = ^offset[1:0];

  always_comb begin
    ack_d = (state_d == ACK);
    dat_d = 32'd0;
    err_d = 1'b0;
    if (ack_d) begin
      if (fault) begin
        err_d = 1'b1;
      end else begin
        dat_d = mem[word_idx];
      end
    end
  end

endmodule

// File: tb/tb_ifetch_responder.sv
// tb_ifetch_responder
//
// Directed bench for ifetch_responder. A table of single fetches with
// hand-computed responses covers hits, window boundaries and faults. The
// multi-cycle corners are hand-written sequences: reset, read-before-write,
// back-to-back fetches, and, when IFETCH_WAITSTATES_EN is defined, wait-state
// latency, abort and reset during WAIT.

module tb_ifetch_responder;

  localparam int AW = 6;

  logic          clk_i = 1'b0;
  logic          reset_i;
  logic [1:0]    isiz_i;
  logic [63:0]   iadr_i;
`ifdef IFETCH_WAITSTATES_EN
  logic [3:0]    ws_i;
`endif
  logic          ld_we_i;
  logic [AW-1:0] ld_adr_i;
  logic [31:0]   ld_dat_i;
  logic          iack_o;
  logic [31:0]   idat_o;
  logic          err_o;

  always #5 clk_i = ~clk_i;

  ifetch_responder #(
    .AW  (AW),
    .BASE(64'hFFFF_FFFF_FFFF_FF00)
  ) dut (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .isiz_i  (isiz_i),
    .iadr_i  (iadr_i),
`ifdef IFETCH_WAITSTATES_EN
    .ws_i    (ws_i),
`endif
    .ld_we_i (ld_we_i),
    .ld_adr_i(ld_adr_i),
    .ld_dat_i(ld_dat_i),
    .iack_o  (iack_o),
    .idat_o  (idat_o),
    .err_o   (err_o)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Advance past the next rising edge and settle.
  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic check_quiet(input string name);
    check({name, " iack"}, {31'd0, iack_o}, 32'd0);
    check({name, " idat"}, idat_o, 32'd0);
    check({name, " err"},  {31'd0, err_o},  32'd0);
  endtask

  task automatic check_resp(input string name, input logic [31:0] dat, input logic err);
    check({name, " iack"}, {31'd0, iack_o}, 32'd1);
    check({name, " idat"}, idat_o, dat);
    check({name, " err"},  {31'd0, err_o},  {31'd0, err});
  endtask

  task automatic load(input logic [AW-1:0] adr, input logic [31:0] dat);
    ld_we_i  = 1'b1;
    ld_adr_i = adr;
    ld_dat_i = dat;
    step();
    ld_we_i  = 1'b0;
  endtask

  // Single zero-wait fetch: response after one edge, quiet after the next.
  task automatic fetch(input string name, input logic [1:0] siz, input logic [63:0] adr,
                       input logic [31:0] dat, input logic err);
    isiz_i = siz;
    iadr_i = adr;
    step();
    check_resp(name, dat, err);
    isiz_i = 2'b00;
    step();
    check_quiet({name, " after"});
  endtask

  typedef struct {
    string       name;
    logic [1:0]  siz;
    logic [63:0] adr;
    logic [31:0] dat;
    logic        err;
  } vec_t;

  vec_t vecs[10];

  initial begin
    vecs[0] = '{"word0",      2'b10, 64'hFFFF_FFFF_FFFF_FF00, 32'h0000_0013, 1'b0};
    vecs[1] = '{"word1",      2'b10, 64'hFFFF_FFFF_FFFF_FF04, 32'h1240_0113, 1'b0};
    vecs[2] = '{"word2",      2'b10, 64'hFFFF_FFFF_FFFF_FF08, 32'hDEAD_BEEF, 1'b0};
    vecs[3] = '{"top_word",   2'b10, 64'hFFFF_FFFF_FFFF_FFFC, 32'hCAFE_F00D, 1'b0};
    vecs[4] = '{"outside",    2'b10, 64'h0000_0000_0000_0124, 32'h0000_0000, 1'b1};
    vecs[5] = '{"misalign",   2'b10, 64'hFFFF_FFFF_FFFF_FF02, 32'h0000_0000, 1'b1};
    vecs[6] = '{"size11",     2'b11, 64'hFFFF_FFFF_FFFF_FF00, 32'h0000_0000, 1'b1};
    vecs[7] = '{"size01",     2'b01, 64'hFFFF_FFFF_FFFF_FF04, 32'h0000_0000, 1'b1};
    vecs[8] = '{"below_base", 2'b10, 64'hFFFF_FFFF_FFFF_FEFC, 32'h0000_0000, 1'b1};
    vecs[9] = '{"above_top",  2'b10, 64'h0000_0000_0000_0000, 32'h0000_0000, 1'b1};

    reset_i  = 1'b0;
    isiz_i   = 2'b00;
    iadr_i   = 64'd0;
`ifdef IFETCH_WAITSTATES_EN
    ws_i     = 4'd0;
`endif
    ld_we_i  = 1'b0;
    ld_adr_i = '0;
    ld_dat_i = 32'd0;

    // Reset held for two edges; a loader write issued during reset must land.
    step();
    check_quiet("reset1");
    load(6'd3, 32'h00A0_0093);
    check_quiet("reset2");
    reset_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check_quiet("idle_after_reset");
    end

    load(6'd0,  32'h0000_0013);
    load(6'd1,  32'h1240_0113);
    load(6'd2,  32'hDEAD_BEEF);
    load(6'd63, 32'hCAFE_F00D);

    for (int i = 0; i < 10; i++) begin
      fetch(vecs[i].name, vecs[i].siz, vecs[i].adr, vecs[i].dat, vecs[i].err);
    end

    fetch("loaded_in_reset", 2'b10, 64'hFFFF_FFFF_FFFF_FF0C, 32'h00A0_0093, 1'b0);

    // Read-before-write: a loader write at the edge that enters ACK must not
    // change the data returned by that fetch.
    isiz_i   = 2'b10;
    iadr_i   = 64'hFFFF_FFFF_FFFF_FF00;
    ld_we_i  = 1'b1;
    ld_adr_i = 6'd0;
    ld_dat_i = 32'h5555_AAAA;
    step();
    ld_we_i  = 1'b0;
    isiz_i   = 2'b00;
    check_resp("rbw_old", 32'h0000_0013, 1'b0);
    step();
    fetch("rbw_new", 2'b10, 64'hFFFF_FFFF_FFFF_FF00, 32'h5555_AAAA, 1'b0);
    load(6'd0, 32'h0000_0013);

    // Back-to-back: a held request is acknowledged every other cycle.
    isiz_i = 2'b10;
    iadr_i = 64'hFFFF_FFFF_FFFF_FF04;
    step();
    check_resp("b2b_first", 32'h1240_0113, 1'b0);
    step();
    check_quiet("b2b_gap");
    step();
    check_resp("b2b_second", 32'h1240_0113, 1'b0);
    isiz_i = 2'b00;
    step();
    check_quiet("b2b_end");

`ifdef IFETCH_WAITSTATES_EN
    // Three wait states: acknowledged four cycles after the first sample.
    // The address, size and ws_i changes during WAIT must be ignored.
    isiz_i = 2'b10;
    iadr_i = 64'hFFFF_FFFF_FFFF_FF04;
    ws_i   = 4'd3;
    step();
    check_quiet("ws3_c1");
    iadr_i = 64'hFFFF_FFFF_FFFF_FF08;
    isiz_i = 2'b11;
    ws_i   = 4'd0;
    step();
    check_quiet("ws3_c2");
    step();
    check_quiet("ws3_c3");
    step();
    check_resp("ws3_ack", 32'h1240_0113, 1'b0);
    isiz_i = 2'b00;
    step();
    check_quiet("ws3_end");

    // Five wait states, dropped after two cycles, then a new zero-wait fetch.
    isiz_i = 2'b10;
    iadr_i = 64'hFFFF_FFFF_FFFF_FF00;
    ws_i   = 4'd5;
    step();
    check_quiet("abort_c1");
    step();
    check_quiet("abort_c2");
    isiz_i = 2'b00;
    step();
    check_quiet("abort_c3");
    isiz_i = 2'b10;
    iadr_i = 64'hFFFF_FFFF_FFFF_FF08;
    ws_i   = 4'd0;
    step();
    check_resp("after_abort", 32'hDEAD_BEEF, 1'b0);
    isiz_i = 2'b00;
    step();
    check_quiet("after_abort_end");

    // Reset during WAIT abandons the fetch for good.
    isiz_i = 2'b10;
    iadr_i = 64'hFFFF_FFFF_FFFF_FF04;
    ws_i   = 4'd4;
    step();
    step();
    reset_i = 1'b0;
    isiz_i  = 2'b00;
    ws_i    = 4'd0;
    step();
    check_quiet("wait_reset1");
    step();
    check_quiet("wait_reset2");
    reset_i = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step();
      check_quiet("post_wait_reset");
    end
    fetch("store_kept", 2'b10, 64'hFFFF_FFFF_FFFF_FF00, 32'h0000_0013, 1'b0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, expected finish before 200000");
    $fatal(1, "timeout");
  end

endmodule
